data_arbiter: RTL and testbench
===============================

# data_arbiter

Two-master arbiter that shares the single data-bus slave port (req/gnt/rvalid protocol, one outstanding transaction) between the core LSU (master 0) and a DMA engine (master 1). It sits between the masters and the bus decoder input. It selects a winner, passes the address phase through, records the owner, and routes the response back. Both masters see the same protocol they would see connected directly to the bus.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports (N ∈ {0,1}, one set per master):
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous assert, active-low
- mN_req_i  in  1  master N request; held with its fields until mN_gnt_o
- mN_we_i  in  1  master N write enable
- mN_be_i  in  DATA_W/8  master N byte enables
- mN_addr_i  in  ADDR_W  master N address
- mN_wdata_i  in  DATA_W  master N write data
- mN_gnt_o  out  1  master N address phase accepted
- mN_rvalid_o  out  1  master N response valid (reads and writes)
- mN_rdata_o  out  DATA_W  master N read data; 0 when mN_rvalid_o=0
- s_req_o  out  1  request to bus
- s_we_o  out  1  write enable to bus
- s_be_o  out  DATA_W/8  byte enables to bus
- s_addr_o  out  ADDR_W  address to bus
- s_wdata_o  out  DATA_W  write data to bus
- s_gnt_i  in  1  bus grant
- s_rvalid_i  in  1  bus response valid
- s_rdata_i  in  DATA_W  bus read data
- busy_o  out  1  transaction outstanding
- owner_o  out  1  index of the current or most recent owner

## Operation
- FSM has two states. IDLE means no transaction is outstanding. RESP means the arbiter is waiting for s_rvalid_i.
- IDLE:
  - The winner is picked combinationally from mN_req_i.
  - s_req_o=1 when any master requests.
  - s_we/be/addr/wdata carry the winner's fields. They are 0 when no master requests.
  - Only the winner sees mN_gnt_o = s_gnt_i.
  - When s_req_o & s_gnt_i: owner ← winner, last ← winner, state ← RESP.
- RESP:
  - s_req_o=0 and both mN_gnt_o=0. Requests are held off.
  - mN_rvalid_o = s_rvalid_i & (owner==N). mN_rdata_o = s_rdata_i gated the same way.
  - When s_rvalid_i: state ← IDLE.
- Arbitration:
  - Only one master requests: that master wins.
  - Both request: the master ≠ last wins (round-robin).
  - last resets to 1, so master 0 wins the first contention.
- A loser keeps mN_req_i high. It sees no gnt until it wins.
- A stray s_rvalid_i in IDLE (e.g. after reset mid-transaction) is dropped. Neither mN_rvalid_o is asserted.
- busy_o = (state==RESP).
- Reset (rst_ni=0):
  - state=IDLE, owner=0, last=1.
  - All outputs 0, including the combinational pass-throughs (gated by reset).
  - A transaction in flight is abandoned. Its master never receives rvalid.

## Timing
- Address phase has zero latency. s_* follows mN_* combinationally. mN_gnt_o follows s_gnt_i in the same cycle.
- Response has zero latency. mN_rvalid_o and mN_rdata_o follow s_rvalid_i and s_rdata_i in the same cycle.
- Slave with gnt=1 and rvalid at +1: issue at cycle t, response at t+1, next issue at t+2. Throughput is 1 transaction per 2 cycles.
- s_gnt_i low in IDLE stalls the arbiter. The winner is recomputed every cycle, so a late-arriving higher-priority requester may take over before gnt. Fields are never mixed between masters within a cycle.
- State, owner and last update only on the rising edge. There is no combinational path from s_rvalid_i to s_req_o.

## Configuration
- DATA_ARB_RR_EN defined: round-robin as described in Operation.
- DATA_ARB_RR_EN undefined:
  - Fixed priority: master 0 always wins contention.
  - The last register is not instantiated.
  - owner_o behaviour is unchanged.

## Structure
- Package data_arb_pkg holds:
  - the state typedef (ARB_IDLE, ARB_RESP)
  - master index constants M_CORE=0 and M_DMA=1
- Sub-module arb_pick2 is the combinational two-way picker: inputs req[1:0] and last; output winner and any. The fixed-priority variant is compiled inside it.
- The top level holds the FSM, the owner/last registers and the muxes.

## Test plan
- m0 reads 0x0000_0010, slave gnt=1 and returns rdata 0xDEADBEEF at +1 → m0_gnt_o at t, m0_rvalid_o with 0xDEADBEEF at t+1, m1 outputs stay 0, busy_o=1 for one cycle.
- m0 and m1 request continuously after reset → grants alternate m0, m1, m0, m1 every 2 cycles. With DATA_ARB_RR_EN undefined, m0 wins every time.
- m1 writes be=4'b0011 to 0x0001_0004 while s_gnt_i=0 for 3 cycles → s_* carries m1 fields all 3 cycles, m1_gnt_o rises on the cycle s_gnt_i=1, then m1_rvalid_o.
- m1 request arrives while m0 is in RESP waiting 4 cycles for rvalid → s_req_o=0 until the response, then m1 is granted on the next cycle.
- rst_ni pulsed low during RESP, then a late s_rvalid_i=1 → all outputs 0 during reset, the stray rvalid is not forwarded, and after release m0 wins the first contention.

Source files
------------

// File: rtl/data_arb_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package data_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker.
// With DATA_ARB_RR_EN defined, contention goes to the master that did not win last.
// Without it, master 0 always wins contention and `last` is ignored.
module arb_pick2
  import data_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

`ifndef DATA_ARB_RR_EN
  // Fixed-priority build has no use for the history bit.
  logic unused_last;
  assign unused_last = last;
`endif

  // Pick one requester; a lone requester always wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    any    = |req;
    winner = M_CORE;
    if (req == 2'b10) begin
      winner = M_DMA;
    end else if (req == 2'b11) begin
`ifdef DATA_ARB_RR_EN
      winner = ~last;
`else
      winner = M_CORE;
`endif
    end
  end

endmodule

// File: rtl/data_arbiter.sv
// Two-master arbiter for the single data-bus slave port (req/gnt/rvalid,
// one outstanding transaction). Master 0 is the core LSU, master 1 the DMA.
// Optional feature macro: DATA_ARB_RR_EN (round-robin contention; otherwise
// fixed priority with master 0 first).
module data_arbiter
  import data_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_gnt_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                busy_o,
  output logic                owner_o
);

  arb_state_e state_q, state_d;
  logic       owner_q;
  logic       last_q;
  logic       winner;
  logic       any;
  logic       idle;
  logic       resp;
  logic       take;

  arb_pick2 u_pick (
    .req    ({m1_req_i, m0_req_i}),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  // Pass-throughs are gated by reset so every output is 0 while rst_ni is low.
  assign idle = rst_ni && (state_q == ARB_IDLE);
  assign resp = rst_ni && (state_q == ARB_RESP);
  assign take = s_req_o & s_gnt_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  // Next state: leave IDLE on an accepted address phase, leave RESP on the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (take)       state_d = ARB_RESP;
      ARB_RESP: if (s_rvalid_i) state_d = ARB_IDLE;
    endcase
  end

  // Remember who owns the outstanding transaction so the response goes back to it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   owner_q <= M_CORE;
    else if (take) owner_q <= winner;
  end

`ifdef DATA_ARB_RR_EN
  // Round-robin history: resets to master 1 so master 0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_q <= M_DMA;
    else if (take) last_q <= winner;
  end
`else
  assign last_q = M_DMA;
`endif

  // Address phase: whole field set of the winner, never mixed; zero when idle.
  always_comb begin
    s_req_o   = idle & any;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      if (winner == M_DMA) begin
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_addr_o  = m1_addr_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_addr_o  = m0_addr_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  // Grants go only to the winner; responses only to the owner, and only in RESP.
  always_comb begin
    m0_gnt_o    = take & (winner == M_CORE);
    m1_gnt_o    = take & (winner == M_DMA);
    m0_rvalid_o = resp & s_rvalid_i & (owner_q == M_CORE);
    m1_rvalid_o = resp & s_rvalid_i & (owner_q == M_DMA);
    m0_rdata_o  = {DATA_W{m0_rvalid_o}} & s_rdata_i;
    m1_rdata_o  = {DATA_W{m1_rvalid_o}} & s_rdata_i;
  end

  assign busy_o  = (state_q == ARB_RESP);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_data_arbiter.sv
// Self-checking bench for data_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_data_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req   [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        busy_o, owner_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: is a transaction outstanding, who owns it, who won last.
  bit mdl_busy;
  int mdl_owner;
  int mdl_last;
  bit granted [2];
  int grant_log [$];

  always #5 clk_i = ~clk_i;

  data_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_req_i    (req[0]),
    .m0_we_i     (we[0]),
    .m0_be_i     (be[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (req[1]),
    .m1_we_i     (we[1]),
    .m1_be_i     (be[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_be_o      (s_be_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_gnt_i     (s_gnt_i),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int n, input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req[n] = r; we[n] = w; be[n] = b; addr[n] = a; wdata[n] = d;
  endtask

  // Who should win this cycle given the current requests.
  function automatic int pick();
    if (req[0] && req[1]) begin
`ifdef DATA_ARB_RR_EN
      return (mdl_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return req[1] ? 1 : 0;
  endfunction

  // One cycle: compare every output against the model, then advance the model at the edge.
  task automatic step(input string tag);
    int          w;
    bit          e_sreq;
    bit          e_gnt [2];
    bit          e_rv  [2];
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    #1;
    if (!rst_ni) begin
      mdl_busy = 0; mdl_owner = 0; mdl_last = 1;
    end
    w      = pick();
    e_sreq = rst_ni && !mdl_busy && (req[0] || req[1]);
    for (int n = 0; n < 2; n++) begin
      e_gnt[n] = e_sreq && s_gnt_i && (w == n);
      e_rv[n]  = rst_ni && mdl_busy && s_rvalid_i && (mdl_owner == n);
    end
    e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
    if (e_sreq) begin
      e_we = we[w]; e_be = be[w]; e_addr = addr[w]; e_wdata = wdata[w];
    end
    check({tag, ".s_req"},    64'(s_req_o),     64'(e_sreq));
    check({tag, ".s_we"},     64'(s_we_o),      64'(e_we));
    check({tag, ".s_be"},     64'(s_be_o),      64'(e_be));
    check({tag, ".s_addr"},   64'(s_addr_o),    64'(e_addr));
    check({tag, ".s_wdata"},  64'(s_wdata_o),   64'(e_wdata));
    check({tag, ".m0_gnt"},   64'(m0_gnt_o),    64'(e_gnt[0]));
    check({tag, ".m1_gnt"},   64'(m1_gnt_o),    64'(e_gnt[1]));
    check({tag, ".m0_rv"},    64'(m0_rvalid_o), 64'(e_rv[0]));
    check({tag, ".m1_rv"},    64'(m1_rvalid_o), 64'(e_rv[1]));
    check({tag, ".m0_rdata"}, 64'(m0_rdata_o),  e_rv[0] ? 64'(s_rdata_i) : 64'd0);
    check({tag, ".m1_rdata"}, 64'(m1_rdata_o),  e_rv[1] ? 64'(s_rdata_i) : 64'd0);
    check({tag, ".busy"},     64'(busy_o),      64'(mdl_busy));
    check({tag, ".owner"},    64'(owner_o),     64'(mdl_owner));
    if (m0_gnt_o === 1'b1) grant_log.push_back(0);
    if (m1_gnt_o === 1'b1) grant_log.push_back(1);
    granted[0] = e_gnt[0];
    granted[1] = e_gnt[1];
    @(posedge clk_i);
    if (!rst_ni) begin
      mdl_busy = 0; mdl_owner = 0; mdl_last = 1;
    end else if (!mdl_busy) begin
      if (e_sreq && s_gnt_i) begin
        mdl_busy = 1; mdl_owner = w; mdl_last = w;
      end
    end else if (s_rvalid_i) begin
      mdl_busy = 0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
    mdl_busy = 0; mdl_owner = 0; mdl_last = 1;
    @(negedge clk_i);

    // Reset: pass-throughs must stay 0 even with requests and bus activity present.
    set_m(0, 1, 1, 4'hF, 32'h1234_5678, 32'h5555_AAAA);
    s_gnt_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'hFFFF_FFFF;
    step("rst0");
    step("rst1");
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    rst_ni = 1'b1;
    step("idle");

    // m0 read, slave grants at once and answers one cycle later.
    set_m(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0);
    s_gnt_i = 1'b1;
    step("t1_issue");
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
    step("t1_resp");
    s_rvalid_i = 1'b0; s_rdata_i = '0;
    step("t1_done");

    // Continuous contention from a fresh reset.
    rst_ni = 1'b0;
    step("t2_rst");
    rst_ni = 1'b1;
    grant_log.delete();
    set_m(0, 1, 0, 4'h3, 32'h0000_0100, 32'h0);
    set_m(1, 1, 1, 4'hC, 32'h0000_0200, 32'h1111_2222);
    s_gnt_i = 1'b1; s_rdata_i = 32'h0BAD_F00D;
    for (int c = 0; c < 8; c++) begin
      s_rvalid_i = mdl_busy;
      step($sformatf("t2_c%0d", c));
    end
    check("t2_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
`ifdef DATA_ARB_RR_EN
      check($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(i % 2));
`else
      check($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'd0);
`endif
    end
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    step("t2_quiet");

    // m1 write stalled by the slave for three cycles.
    grant_log.delete();
    set_m(1, 1, 1, 4'b0011, 32'h0001_0004, 32'hCAFE_F00D);
    for (int c = 0; c < 3; c++) step($sformatf("t3_stall%0d", c));
    check("t3_no_gnt", 64'(grant_log.size()), 64'd0);
    s_gnt_i = 1'b1;
    step("t3_gnt");
    set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
    step("t3_resp");
    s_rvalid_i = 1'b0;
    check("t3_winner", 64'(grant_log.size()), 64'd1);

    // m1 arrives while m0 waits four cycles for its response.
    grant_log.delete();
    set_m(0, 1, 0, 4'hF, 32'h0000_0020, 32'h0);
    s_gnt_i = 1'b1;
    step("t4_m0");
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1, 0, 4'hF, 32'h0000_0030, 32'h0);
    for (int c = 0; c < 4; c++) step($sformatf("t4_wait%0d", c));
    s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_1234;
    step("t4_resp");
    s_rvalid_i = 1'b0;
    step("t4_m1");
    check("t4_order", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("t4_second", 64'(grant_log[1]), 64'd1);
    set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h0000_5678;
    step("t4_m1_resp");
    s_rvalid_i = 1'b0;

    // Reset in RESP, late stray response, then first contention.
    grant_log.delete();
    set_m(1, 1, 1, 4'h1, 32'h0000_0040, 32'h7777_7777);
    s_gnt_i = 1'b1;
    step("t5_issue");
    set_m(0, 1, 0, 4'hF, 32'h0000_0050, 32'h0);
    s_gnt_i = 1'b0;
    rst_ni = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hAAAA_5555;
    step("t5_rst");
    rst_ni = 1'b1; s_gnt_i = 1'b1;
    step("t5_stray");
    check("t5_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("t5_first", 64'(grant_log[1]), 64'd0);
    set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
    s_gnt_i = 1'b0;
    step("t5_resp");
    s_rvalid_i = 1'b0;

    // Random traffic; masters keep request and fields until granted.
    granted[0] = 0; granted[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n] || granted[n]) begin
          set_m(n, $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom),
                $urandom, $urandom);
        end
      end
      s_gnt_i    = ($urandom_range(0, 2) != 0);
      s_rvalid_i = mdl_busy ? $urandom_range(0, 1) : ($urandom_range(0, 7) == 0);
      s_rdata_i  = $urandom;
      if (!rst_ni)                           rst_ni = 1'b1;
      else if ($urandom_range(0, 63) == 0)   rst_ni = 1'b0;
      step($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
